// File: rtl/sprite_anim_gen.sv
// Animated square-sprite pixel generator: hit test, sprite ROM addressing by
// facing/frame/offset, hop animation FSM and a fixed 2-cycle colour pipeline.
module sprite_anim_gen #(
  parameter int                 SIZE_LOG2   = 5,
  parameter int                 FRAME_BITS  = 2,
  parameter int                 FRAME_TICKS = 4,
  parameter int                 COLOR_W     = 6,
  parameter logic [COLOR_W-1:0] BG_COLOR    = {COLOR_W{1'b0}},
  localparam int                ADDR_W      = 2 + FRAME_BITS + 2 * SIZE_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [9:0]            colPos,
  input  logic [9:0]            rowPos,
  input  logic [9:0]            sprite_x,
  input  logic [9:0]            sprite_y,
  input  logic [1:0]            facing,
  input  logic                  hop_start,
  output logic                  hop_busy,
  output logic [FRAME_BITS-1:0] anim_frame,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [COLOR_W-1:0]    rom_data,
  output logic [COLOR_W-1:0]    color,
  output logic                  in_sprite
);

  localparam int SIZE   = 2 ** SIZE_LOG2;
  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_BITS-1:0] FRAME_LAST = {FRAME_BITS{1'b1}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOP  = 1'b1
  } state_e;

  state_e                state_q;
  logic [FRAME_BITS-1:0] anim_frame_q;
  logic [TICK_W-1:0]     tick_cnt_q;
  logic [1:0]            facing_lat_q;
  logic                  hit_d1_q;
  logic                  in_sprite_q;
  logic [COLOR_W-1:0]    color_q;

  logic [10:0]           x_end_s;
  logic [10:0]           y_end_s;
  logic                  hit_s;
  logic [SIZE_LOG2-1:0]  local_x_s;
  logic [SIZE_LOG2-1:0]  local_y_s;
  logic [1:0]            facing_eff_s;
  logic [ADDR_W-1:0]     rom_addr_s;

  // 11-bit bounds so a sprite near column/row 1023 never wraps back to 0
  assign x_end_s   = {1'b0, sprite_x} + 11'(SIZE);
  assign y_end_s   = {1'b0, sprite_y} + 11'(SIZE);
  assign hit_s     = (colPos >= sprite_x) && ({1'b0, colPos} < x_end_s) &&
                     (rowPos >= sprite_y) && ({1'b0, rowPos} < y_end_s);
  assign local_x_s = colPos[SIZE_LOG2-1:0] - sprite_x[SIZE_LOG2-1:0];
  assign local_y_s = rowPos[SIZE_LOG2-1:0] - sprite_y[SIZE_LOG2-1:0];

  always_comb begin
    facing_eff_s = facing;
    rom_addr_s   = {ADDR_W{1'b0}};
    if (state_q == S_HOP) begin
      facing_eff_s = facing_lat_q;
    end else begin
      facing_eff_s = facing;
    end
    if (hit_s) begin
      rom_addr_s = {facing_eff_s, anim_frame_q, local_y_s, local_x_s};
    end else begin
      rom_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Hop FSM: frame_tick is ignored on the cycle a hop is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      anim_frame_q <= {FRAME_BITS{1'b0}};
      tick_cnt_q   <= {TICK_W{1'b0}};
      facing_lat_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hop_start) begin
            state_q      <= S_HOP;
            anim_frame_q <= FRAME_BITS'(1);
            tick_cnt_q   <= {TICK_W{1'b0}};
            facing_lat_q <= facing;
          end
        end
        S_HOP: begin
          if (frame_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= {TICK_W{1'b0}};
              if (anim_frame_q == FRAME_LAST) begin
                state_q      <= S_IDLE;
                anim_frame_q <= {FRAME_BITS{1'b0}};
              end else begin
                anim_frame_q <= anim_frame_q + FRAME_BITS'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
          end
        end
        default: begin
          state_q      <= S_IDLE;
          anim_frame_q <= {FRAME_BITS{1'b0}};
          tick_cnt_q   <= {TICK_W{1'b0}};
        end
      endcase
    end
  end

  // Colour pipeline: hit delayed one cycle to line up with the ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d1_q    <= 1'b0;
      in_sprite_q <= 1'b0;
      color_q     <= BG_COLOR;
    end else begin
      hit_d1_q    <= hit_s;
      in_sprite_q <= hit_d1_q;
      color_q     <= hit_d1_q ? rom_data : BG_COLOR;
    end
  end

  assign hop_busy   = (state_q == S_HOP);
  assign anim_frame = anim_frame_q;
  assign rom_addr   = rom_addr_s;
  assign color      = color_q;
  assign in_sprite  = in_sprite_q;

endmodule

// File: doc/sprite_anim_gen.md
Name: sprite_anim_gen

Overview:
- Parametrised sprite pixel generator; successor to the single-frame frog sprite generator.
- Per pixel, it tests whether the current raster position (colPos, rowPos) lies inside a square sprite. It then addresses an external synchronous sprite ROM by facing, animation frame and local offset, and returns the ROM colour or a background colour.
- Adds a hop animation state machine paced by a per-video-frame tick, plus a 2-cycle pipelined ROM path.
- Sits between the VGA timing block and the colour mux; one instance per animated sprite (frog, enemies).

Parameters:
- SIZE_LOG2, 5, sprite edge = 2**SIZE_LOG2 pixels (32).
- FRAME_BITS, 2, animation frame index width; FRAMES = 2**FRAME_BITS (4).
- FRAME_TICKS, 4, frame_tick pulses each non-zero animation frame is held; must be >= 1.
- COLOR_W, 6, colour width (RRGGBB).
- BG_COLOR, 6'b000000, colour driven when pixel is outside the sprite.
- ADDR_W, 2+FRAME_BITS+2*SIZE_LOG2, derived ROM address width; not overridable.

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank)
- colPos  in  10  current pixel column
- rowPos  in  10  current pixel row
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- facing  in  2  00 up, 01 down, 10 left, 11 right
- hop_start  in  1  one-cycle request to play the hop animation
- hop_busy  out  1  high while the hop animation plays
- anim_frame  out  FRAME_BITS  current animation frame (0 = rest pose)
- rom_addr  out  ADDR_W  sprite ROM address {facing_eff, anim_frame, local_y, local_x}
- rom_data  in  COLOR_W  ROM output; valid the cycle after rom_addr
- color  out  COLOR_W  pixel colour, 2 cycles after colPos/rowPos
- in_sprite  out  1  hit flag, cycle-aligned with color

Behaviour:
- Reset values: hop_busy=0, anim_frame=0, color=BG_COLOR, in_sprite=0, both hit pipeline stages=0, tick_cnt=0, facing_lat=00. rst overrides every other input, including a mid-hop state.
- Hit test (cycle N, combinational): all arithmetic is done in 11 bits, so sprite_x+2**SIZE_LOG2 never wraps.
  - hit = colPos>=sprite_x && colPos<sprite_x+SIZE && rowPos>=sprite_y && rowPos<sprite_y+SIZE.
  - A sprite placed near 1023 does not alias to column 0.
- rom_addr (cycle N, combinational): local_x = colPos-sprite_x and local_y = rowPos-sprite_y, each truncated to SIZE_LOG2 bits.
  - When hit=0, rom_addr=0.
  - facing_eff = facing_lat while hop_busy, else the live facing input.
- Pipeline: hit is registered into hit_d1 at the end of cycle N. At the end of cycle N+1:
  - in_sprite <= hit_d1.
  - color <= hit_d1 ? rom_data : BG_COLOR.
  - Fixed latency is 2 cycles, with no stalls; the caller delays hsync/vsync by 2 to match.
- Animation FSM, states IDLE and HOP:
  - IDLE: hop_busy=0, anim_frame=0. On hop_start: go to HOP, anim_frame<=1, tick_cnt<=0, facing_lat<=facing.
  - HOP: hop_busy=1. On each frame_tick:
    - If tick_cnt==FRAME_TICKS-1: tick_cnt<=0. Then, if anim_frame==FRAMES-1, go to IDLE with anim_frame<=0; otherwise anim_frame<=anim_frame+1.
    - Otherwise tick_cnt<=tick_cnt+1.
  - Duration: hop_busy stays high for exactly (FRAMES-1)*FRAME_TICKS frame_ticks.
- Boundary cases:
  - hop_start while in HOP is ignored; no queueing and no restart.
  - hop_start and frame_tick in the same IDLE cycle: enter HOP; that tick is not counted.
  - Return to IDLE and a new hop_start in the same cycle: hop_start is ignored; a fresh request is needed next cycle.
  - facing changes during HOP do not affect rom_addr until IDLE.
  - anim_frame and facing_eff may change mid-line; the address uses their values in the cycle the pixel is sampled.
  - FRAMES=1 (FRAME_BITS=0 is disallowed): FRAME_BITS must be >=1.

Test Plan:
- Reset: assert rst 3 cycles mid-hop -> next cycle hop_busy=0, anim_frame=0, color=0, in_sprite=0.
- Static hit: sprite (100,200), facing=01, IDLE, pixel (105,203) -> rom_addr={01,00,00011,00101}; two cycles later in_sprite=1 and color=rom_data driven by the bench. Pixel (132,203) -> in_sprite=0, color=0.
- Hop sequence, FRAME_TICKS=2: pulse hop_start with facing=11 -> anim_frame 1,1,2,2,3,3 across ticks. After the 6th tick: anim_frame=0, hop_busy=0. facing changed to 00 mid-hop -> rom_addr[top2]=11 until IDLE.
- Wrap: sprite_x=1010, colPos=5, rowPos inside range -> in_sprite=0 two cycles later. colPos=1015 -> in_sprite=1 with local_x=5.
- Collisions: hop_start during HOP -> no restart; tick count unchanged. hop_start with frame_tick in IDLE -> anim_frame=1 and the first counted tick is the next one.
- Pipeline alignment: sweep colPos 95..140 on one row -> in_sprite high for exactly 32 consecutive cycles, starting 2 cycles after colPos=100.
